// File: rtl/out_arbiter.sv
// out_arbiter: round-robin collector of per-core results into a small output FIFO.
// Optional saturating stall counter (stall_cnt port) is built when OUT_ARBITER_STALL_CNT_EN is defined.
module out_arbiter #(
  parameter int NCORES = 34,
  parameter int DW     = 28,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    core_vld,
  input  logic [NCORES*DW-1:0] core_data,
  output logic [NCORES-1:0]    core_ack,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [5:0]           out_core,
  input  logic                 out_ready
`ifdef OUT_ARBITER_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int IW = $clog2(NCORES);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 6 + DW;

  logic [NCORES-1:0] ack_q, ack_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic              armed_q;
  logic [EW-1:0]     mem_q [DEPTH];

  logic [NCORES-1:0] eligible_s;
  logic              pop_s, full_s, empty_s, can_push_s;
  logic              found_s, grant_s;
  logic [IW-1:0]     gnt_idx_s;
  logic [7:0]        cand_s;
  logic [EW-1:0]     wr_entry_s;

  // A core whose ack is currently high has already been taken; never grant it twice.
  assign eligible_s = core_vld & ~ack_q;
  assign empty_s    = (wr_q == rd_q);
  assign full_s     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_s      = ~empty_s & out_ready;
  assign can_push_s = ~full_s | pop_s;

  // Round-robin search starting one past the last granted core, wrapping at NCORES.
  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = {IW{1'b0}};
    cand_s    = 8'd0;
    for (int i = 0; i < NCORES; i++) begin
      cand_s = 8'(ptr_q) + 8'(i) + 8'd1;
      if (cand_s >= 8'(NCORES)) begin
        cand_s = cand_s - 8'(NCORES);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && eligible_s[cand_s[IW-1:0]]) begin
        found_s   = 1'b1;
        gnt_idx_s = cand_s[IW-1:0];
      end else begin
        found_s   = found_s;
        gnt_idx_s = gnt_idx_s;
      end
    end
  end

  // Grant, pointer and FIFO index next-state.
  always_comb begin
    ack_d      = {NCORES{1'b0}};
    ptr_d      = ptr_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    grant_s    = found_s & armed_q & can_push_s;
    wr_entry_s = {6'(gnt_idx_s), core_data[32'(gnt_idx_s) * DW +: DW]};
    if (grant_s) begin
      ack_d = {{(NCORES-1){1'b0}}, 1'b1} << gnt_idx_s;
      ptr_d = gnt_idx_s;
      wr_d  = wr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      ack_d = {NCORES{1'b0}};
      ptr_d = ptr_q;
      wr_d  = wr_q;
    end
    if (pop_s) begin
      rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_d = rd_q;
    end
  end

  // Control state; armed_q holds off grants for the first cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= {NCORES{1'b0}};
      ptr_q   <= IW'(NCORES - 1);
      wr_q    <= {(AW+1){1'b0}};
      rd_q    <= {(AW+1){1'b0}};
      armed_q <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      armed_q <= 1'b1;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= {EW{1'b0}};
      end
    end else if (grant_s) begin
      mem_q[wr_q[AW-1:0]] <= wr_entry_s;
    end else begin
      mem_q[wr_q[AW-1:0]] <= mem_q[wr_q[AW-1:0]];
    end
  end

  assign core_ack  = ack_q;
  assign out_valid = ~empty_s;
  assign out_core  = mem_q[rd_q[AW-1:0]][EW-1:DW];
  assign out_data  = mem_q[rd_q[AW-1:0]][DW-1:0];

`ifdef OUT_ARBITER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Count cycles where a core is waiting but the FIFO cannot accept it.
  always_comb begin
    stall_d = stall_q;
    if (full_s && !pop_s && (|eligible_s) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
